// File: rtl/mcu_bus_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mcu_bus_if : 8051 external-bus slave with control, status and event regs  |
// | Revision   : 1.0                                                           |
// +---------------------------------------------------------------------------+
module mcu_bus_if #(
  parameter int          NUM_REGS    = 8,
  parameter logic [15:0] BASE_ADDR   = 16'h8000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  cs_n,
  input  logic                  ale,
  input  logic                  w_n,
  input  logic                  r_n,
  input  logic [7:0]            abus,
  input  logic [7:0]            dbus_in,
  output logic [7:0]            dbus_out,
  output logic                  dbus_oe,
  output logic [8*NUM_REGS-1:0] ctrl_q,
  output logic [NUM_REGS-1:0]   ctrl_wr_stb,
  input  logic [8*NUM_REGS-1:0] sts_in,
  input  logic [NUM_REGS-1:0]   evt_in
);

  localparam int DEPTH = SYNC_STAGES + 1;
  localparam int EVW   = (NUM_REGS < 8) ? NUM_REGS : 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    RELEASE = 2'd2
  } rd_state_e;

  logic [DEPTH-1:0]      cs_sync_q, cs_sync_d;
  logic [DEPTH-1:0]      ale_sync_q, ale_sync_d;
  logic [DEPTH-1:0]      w_sync_q, w_sync_d;
  logic [DEPTH-1:0]      r_sync_q, r_sync_d;
  logic [DEPTH-1:0][7:0] abus_sync_q, abus_sync_d;
  logic [DEPTH-1:0][7:0] dbus_sync_q, dbus_sync_d;

  logic [15:0]           addr_q, addr_d;
  logic [8*NUM_REGS-1:0] ctrl_d;
  logic [NUM_REGS-1:0]   stb_q, stb_d;
  logic [NUM_REGS-1:0]   evt_q, evt_d;
  logic [NUM_REGS-1:0]   evt_cap_q, evt_cap_d;
  logic [NUM_REGS-1:0]   evt_clr;
  logic                  evt_rd_q, evt_rd_d;
  logic                  pend_q, pend_d;
  rd_state_e             state_q, state_d;
  logic [7:0]            dbus_out_q, dbus_out_d;
  logic                  dbus_oe_q, dbus_oe_d;

  logic                  cs_act, ale_fall, w_rise, r_fall, r_rise;
  logic [15:0]           offset;
  logic [7:0]            rd_data;
  logic                  evt_hit;

  // Stage 0 takes the pin; stage DEPTH-2 is the last sync stage, DEPTH-1 the delay stage.
  always_comb begin
    cs_sync_d   = {cs_sync_q[DEPTH-2:0], cs_n};
    ale_sync_d  = {ale_sync_q[DEPTH-2:0], ale};
    w_sync_d    = {w_sync_q[DEPTH-2:0], w_n};
    r_sync_d    = {r_sync_q[DEPTH-2:0], r_n};
    abus_sync_d = {abus_sync_q[DEPTH-2:0], abus};
    dbus_sync_d = {dbus_sync_q[DEPTH-2:0], dbus_in};
  end

  always_comb begin
    cs_act   = ~cs_sync_q[DEPTH-1];
    ale_fall = ~ale_sync_q[DEPTH-2] &  ale_sync_q[DEPTH-1];
    w_rise   =  w_sync_q[DEPTH-2]   & ~w_sync_q[DEPTH-1];
    r_fall   = ~r_sync_q[DEPTH-2]   &  r_sync_q[DEPTH-1];
    r_rise   =  r_sync_q[DEPTH-2]   & ~r_sync_q[DEPTH-1];
    offset   = addr_q - BASE_ADDR;
  end

  // Addresses below BASE_ADDR wrap to large offsets and decode as out of range.
  always_comb begin
    rd_data = 8'hFF;
    evt_hit = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (offset == 16'(k))            rd_data = ctrl_q[8*k +: 8];
      if (offset == 16'(NUM_REGS + k)) rd_data = sts_in[8*k +: 8];
    end
    if (offset == 16'(2*NUM_REGS)) begin
      rd_data          = 8'h00;
      rd_data[EVW-1:0] = evt_q[EVW-1:0];
      evt_hit          = 1'b1;
    end
  end

  always_comb begin
    addr_d     = addr_q;
    ctrl_d     = ctrl_q;
    stb_d      = '0;
    state_d    = state_q;
    dbus_out_d = dbus_out_q;
    evt_cap_d  = evt_cap_q;
    evt_rd_d   = evt_rd_q;
    pend_d     = pend_q;
    evt_clr    = '0;

    if (ale_fall && cs_act) begin
      addr_d = {abus_sync_q[DEPTH-1], dbus_sync_q[DEPTH-1]};
    end

    if (w_rise && cs_act) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (offset == 16'(k)) begin
          ctrl_d[8*k +: 8] = dbus_sync_q[DEPTH-1];
          stb_d[k]         = 1'b1;
        end
      end
    end

    unique case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        if ((r_fall || pend_q) && cs_act) begin
          state_d              = DRIVE;
          dbus_out_d           = rd_data;
          evt_rd_d             = evt_hit;
          evt_cap_d            = '0;
          evt_cap_d[EVW-1:0]   = evt_q[EVW-1:0];
        end
      end
      DRIVE: begin
        if (!cs_act) begin
          state_d = RELEASE;
        end else if (r_rise) begin
          state_d = RELEASE;
          if (evt_rd_q) evt_clr = evt_cap_q;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        if (r_fall && cs_act) pend_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // New pulses win over a simultaneous clear.
    evt_d     = (evt_q & ~evt_clr) | evt_in;
    dbus_oe_d = (state_d == DRIVE);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      cs_sync_q   <= '1;
      ale_sync_q  <= '0;
      w_sync_q    <= '1;
      r_sync_q    <= '1;
      abus_sync_q <= '0;
      dbus_sync_q <= '0;
      addr_q      <= '0;
      ctrl_q      <= '0;
      stb_q       <= '0;
      evt_q       <= '0;
      evt_cap_q   <= '0;
      evt_rd_q    <= 1'b0;
      pend_q      <= 1'b0;
      state_q     <= IDLE;
      dbus_out_q  <= '0;
      dbus_oe_q   <= 1'b0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      ale_sync_q  <= ale_sync_d;
      w_sync_q    <= w_sync_d;
      r_sync_q    <= r_sync_d;
      abus_sync_q <= abus_sync_d;
      dbus_sync_q <= dbus_sync_d;
      addr_q      <= addr_d;
      ctrl_q      <= ctrl_d;
      stb_q       <= stb_d;
      evt_q       <= evt_d;
      evt_cap_q   <= evt_cap_d;
      evt_rd_q    <= evt_rd_d;
      pend_q      <= pend_d;
      state_q     <= state_d;
      dbus_out_q  <= dbus_out_d;
      dbus_oe_q   <= dbus_oe_d;
    end
  end

  assign dbus_out    = dbus_out_q;
  assign dbus_oe     = dbus_oe_q;
  assign ctrl_wr_stb = stb_q;

endmodule
`default_nettype wire

// File: tb/tb_mcu_bus_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_mcu_bus_if : directed self-checking bench for mcu_bus_if (8 registers) |
// | Revision      : 1.0                                                       |
// +---------------------------------------------------------------------------+
module tb_mcu_bus_if;

  logic        clock = 1'b0;
  logic        rst;
  logic        cs_n, ale, w_n, r_n;
  logic [7:0]  abus, dbus_in;
  logic [7:0]  dbus_out;
  logic        dbus_oe;
  logic [63:0] ctrl_q;
  logic [7:0]  ctrl_wr_stb;
  logic [63:0] sts_in;
  logic [7:0]  evt_in;

  int errors = 0;
  int checks = 0;

  mcu_bus_if #(
    .NUM_REGS   (8),
    .BASE_ADDR  (16'h8000),
    .SYNC_STAGES(2)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .cs_n       (cs_n),
    .ale        (ale),
    .w_n        (w_n),
    .r_n        (r_n),
    .abus       (abus),
    .dbus_in    (dbus_in),
    .dbus_out   (dbus_out),
    .dbus_oe    (dbus_oe),
    .ctrl_q     (ctrl_q),
    .ctrl_wr_stb(ctrl_wr_stb),
    .sts_in     (sts_in),
    .evt_in     (evt_in)
  );

  always #5 clock = ~clock;

  // Advance n rising edges and settle 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_ale(input logic [15:0] a);
    cs_n    = 1'b0;
    abus    = a[15:8];
    dbus_in = a[7:0];
    ale     = 1'b1;
    tick(3);
    ale = 1'b0;
    tick(4);
  endtask

  // Full read; evt_at_clear is pulsed into evt_in during the cycle the clear lands.
  task automatic do_read(output logic [7:0] data, input logic [7:0] evt_at_clear);
    r_n = 1'b0;
    tick(4);
    data = dbus_out;
    r_n  = 1'b1;
    tick(2);
    evt_in = evt_at_clear;
    tick(1);
    evt_in = 8'h00;
    tick(3);
  endtask

  task automatic pulse_evt(input logic [7:0] v);
    evt_in = v;
    tick(1);
    evt_in = 8'h00;
    tick(1);
  endtask

  task automatic test_reset;
    cs_n = 1'b1; ale = 1'b0; w_n = 1'b1; r_n = 1'b1;
    abus = 8'h00; dbus_in = 8'h00; sts_in = '0; evt_in = 8'h00;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(3);
    checks++; if (ctrl_q !== 64'h0) begin errors++; $display("FAIL reset_ctrl: got %h want %h", ctrl_q, 64'h0); end
    checks++; if (dbus_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", dbus_oe); end
    checks++; if (dbus_out !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", dbus_out); end
    checks++; if (ctrl_wr_stb !== 8'h00) begin errors++; $display("FAIL reset_stb: got %h want 00", ctrl_wr_stb); end
  endtask

  task automatic test_write;
    do_ale(16'h8003);
    dbus_in = 8'hA5;
    w_n = 1'b0;
    tick(3);
    w_n = 1'b1;
    tick(2);
    checks++; if (ctrl_wr_stb !== 8'h00) begin errors++; $display("FAIL wr_stb_early: got %h want 00", ctrl_wr_stb); end
    tick(1);
    checks++; if (ctrl_wr_stb !== 8'h08) begin errors++; $display("FAIL wr_stb_pulse: got %h want 08", ctrl_wr_stb); end
    checks++; if (ctrl_q !== 64'h00000000_A5000000) begin errors++; $display("FAIL wr_ctrl: got %h want %h", ctrl_q, 64'h00000000_A5000000); end
    tick(1);
    checks++; if (ctrl_wr_stb !== 8'h00) begin errors++; $display("FAIL wr_stb_width: got %h want 00", ctrl_wr_stb); end
    tick(3);
  endtask

  task automatic test_read;
    logic [7:0] d;
    r_n = 1'b0;
    tick(2);
    checks++; if (dbus_oe !== 1'b0) begin errors++; $display("FAIL rd_oe_early: got %b want 0", dbus_oe); end
    tick(1);
    checks++; if (dbus_oe !== 1'b1) begin errors++; $display("FAIL rd_oe_rise: got %b want 1", dbus_oe); end
    checks++; if (dbus_out !== 8'hA5) begin errors++; $display("FAIL rd_data: got %h want A5", dbus_out); end
    tick(3);
    checks++; if (dbus_out !== 8'hA5 || dbus_oe !== 1'b1) begin errors++; $display("FAIL rd_hold: got %h/%b want A5/1", dbus_out, dbus_oe); end
    r_n = 1'b1;
    tick(2);
    checks++; if (dbus_oe !== 1'b1) begin errors++; $display("FAIL rd_oe_hold: got %b want 1", dbus_oe); end
    tick(1);
    checks++; if (dbus_oe !== 1'b0) begin errors++; $display("FAIL rd_oe_fall: got %b want 0", dbus_oe); end
    tick(3);
    sts_in = 64'h00000000_003C0000;
    do_ale(16'h800A);
    do_read(d, 8'h00);
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL rd_status: got %h want 3C", d); end
    sts_in = '0;
  endtask

  task automatic test_out_of_range;
    logic [7:0] d;
    logic [7:0] seen;
    do_ale(16'h9000);
    dbus_in = 8'h5A;
    w_n = 1'b0;
    tick(3);
    w_n  = 1'b1;
    seen = 8'h00;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      seen = seen | ctrl_wr_stb;
    end
    checks++; if (seen !== 8'h00) begin errors++; $display("FAIL oor_stb: got %h want 00", seen); end
    checks++; if (ctrl_q !== 64'h00000000_A5000000) begin errors++; $display("FAIL oor_ctrl: got %h want %h", ctrl_q, 64'h00000000_A5000000); end
    do_read(d, 8'h00);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL oor_read: got %h want FF", d); end
  endtask

  task automatic test_events;
    logic [7:0] d;
    pulse_evt(8'h22);
    do_ale(16'h8010);
    do_read(d, 8'h02);
    checks++; if (d !== 8'h22) begin errors++; $display("FAIL evt_read: got %h want 22", d); end
    do_read(d, 8'h00);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL evt_set_wins: got %h want 02", d); end
    do_read(d, 8'h00);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL evt_cleared: got %h want 00", d); end
  endtask

  task automatic test_chip_select;
    logic [7:0] d;
    logic       dropped;
    do_ale(16'h8003);
    cs_n    = 1'b1;
    tick(4);
    dbus_in = 8'h11;
    w_n = 1'b0;
    tick(3);
    w_n = 1'b1;
    tick(6);
    checks++; if (ctrl_q !== 64'h00000000_A5000000) begin errors++; $display("FAIL cs_write_ignored: got %h want %h", ctrl_q, 64'h00000000_A5000000); end
    cs_n = 1'b0;
    tick(3);
    pulse_evt(8'h04);
    do_ale(16'h8010);
    r_n = 1'b0;
    tick(4);
    checks++; if (dbus_oe !== 1'b1 || dbus_out !== 8'h04) begin errors++; $display("FAIL cs_read_start: got %h/%b want 04/1", dbus_out, dbus_oe); end
    cs_n    = 1'b1;
    dropped = 1'b0;
    for (int i = 0; i < 6 && !dropped; i++) begin
      tick(1);
      if (dbus_oe === 1'b0) dropped = 1'b1;
    end
    checks++; if (dropped !== 1'b1) begin errors++; $display("FAIL cs_abort_oe: got oe=%b want 0 within 6 cycles", dbus_oe); end
    r_n = 1'b1;
    tick(4);
    cs_n = 1'b0;
    tick(4);
    do_read(d, 8'h00);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL cs_evt_retained: got %h want 04", d); end
  endtask

  task automatic test_back_to_back;
    logic rose;
    do_ale(16'h8003);
    r_n = 1'b0;
    tick(4);
    r_n = 1'b1;
    tick(2);
    r_n  = 1'b0;
    rose = 1'b0;
    tick(2);
    for (int i = 0; i < 6 && !rose; i++) begin
      tick(1);
      if (dbus_oe === 1'b1) rose = 1'b1;
    end
    checks++; if (rose !== 1'b1) begin errors++; $display("FAIL b2b_second_oe: got oe=%b want 1 within 8 cycles", dbus_oe); end
    checks++; if (dbus_out !== 8'hA5) begin errors++; $display("FAIL b2b_second_data: got %h want A5", dbus_out); end
    r_n = 1'b1;
    tick(5);
  endtask

  task automatic test_reset_mid_read;
    logic [7:0] seen;
    logic       oe_seen;
    r_n = 1'b0;
    tick(4);
    checks++; if (dbus_oe !== 1'b1) begin errors++; $display("FAIL rst_read_start: got %b want 1", dbus_oe); end
    rst = 1'b1;
    tick(1);
    checks++; if (dbus_oe !== 1'b0) begin errors++; $display("FAIL rst_oe: got %b want 0", dbus_oe); end
    checks++; if (ctrl_q !== 64'h0) begin errors++; $display("FAIL rst_ctrl: got %h want 0", ctrl_q); end
    r_n = 1'b1;
    tick(2);
    rst     = 1'b0;
    seen    = 8'h00;
    oe_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      seen    = seen | ctrl_wr_stb;
      oe_seen = oe_seen | dbus_oe;
    end
    checks++; if (seen !== 8'h00 || oe_seen !== 1'b0) begin errors++; $display("FAIL rst_release_quiet: got stb=%h oe=%b want 00/0", seen, oe_seen); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_out_of_range();
    test_events();
    test_chip_select();
    test_back_to_back();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
